// File: rtl/axi_slv_pkg.sv
// rtl/axi_slv_pkg.sv - shared burst, response and FSM state types for axi_slave_mem
package axi_slv_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

endpackage

// File: rtl/axi_slv_addr_gen.sv
// rtl/axi_slv_addr_gen.sv - combinational next-beat address for FIXED/INCR/WRAP bursts
module axi_slv_addr_gen
    import axi_slv_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [3:0]  len,
    input  logic [1:0]  burst,
    output logic [31:0] next_addr
);

    logic [31:0] incr_addr;
    logic [31:0] wrap_mask;
    logic        wrap_ok;

    always_comb begin
        incr_addr = addr + (32'd1 << size);
        wrap_mask = (({28'd0, len} + 32'd1) << size) - 32'd1;
        wrap_ok   = (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
        // Illegal WRAP lengths and the reserved burst code both fall back to INCR
        if (burst == FIXED) begin
            next_addr = addr;
        end else if ((burst == WRAP) && wrap_ok) begin
            next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
        end else begin
            next_addr = incr_addr;
        end
    end

endmodule

// File: rtl/axi_slave_mem.sv
// rtl/axi_slave_mem.sv - AXI3-style slave with word-addressed memory
// AXI_SLV_WID_CHECK_EN: reject W beats whose wid differs from the captured awid
module axi_slave_mem
    import axi_slv_pkg::*;
#(
    parameter int MEM_DEPTH = 64
) (
    input  logic        aclk,
    input  logic        arst,
    input  logic [3:0]  awid,
    input  logic [3:0]  awlen,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready,
    input  logic [3:0]  arid,
    input  logic [3:0]  arlen,
    input  logic [31:0] araddr,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready
);

    localparam int AW = $clog2(MEM_DEPTH);

    w_state_t    w_state, w_state_nxt;
    r_state_t    r_state, r_state_nxt;
    logic        rst_done;

    logic [3:0]  w_id, w_len, w_cnt;
    logic [31:0] w_addr, w_next;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_err;

    logic [3:0]  r_id, r_len, r_cnt;
    logic [31:0] r_addr, r_next;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [31:0] r_data_q;
    logic [1:0]  r_resp_q;

    logic [31:0] mem [MEM_DEPTH];

    logic        aw_hs, w_hs, ar_hs, r_hs;
    logic        w_last_beat, r_last_beat;
    logic        wid_ok, w_beat_ok, w_mem_en;
    logic [31:0] ld_addr, ld_data;
    logic [2:0]  ld_size;
    logic        ld_ok;

    function automatic logic in_range(input logic [31:0] a);
        return a[31:AW+2] == '0;
    endfunction

`ifdef AXI_SLV_WID_CHECK_EN
    assign wid_ok = (wid == w_id);
`else
    logic unused_wid;
    assign unused_wid = ^wid;
    assign wid_ok     = 1'b1;
`endif

    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;
    assign ar_hs       = arvalid && arready;
    assign r_hs        = rvalid && rready;
    assign w_last_beat = (w_cnt == w_len);
    assign r_last_beat = (r_cnt == r_len);
    assign w_beat_ok   = (w_size <= 3'd2) && in_range(w_addr) && wid_ok;
    assign w_mem_en    = w_hs && w_beat_ok && !arst;

    axi_slv_addr_gen u_wr_addr (
        .addr      (w_addr),
        .size      (w_size),
        .len       (w_len),
        .burst     (w_burst),
        .next_addr (w_next)
    );

    axi_slv_addr_gen u_rd_addr (
        .addr      (r_addr),
        .size      (r_size),
        .len       (r_len),
        .burst     (r_burst),
        .next_addr (r_next)
    );

    always_ff @(posedge aclk) begin
        if (arst) begin
            w_state  <= W_IDLE;
            r_state  <= R_IDLE;
            rst_done <= 1'b0;
        end else begin
            w_state  <= w_state_nxt;
            r_state  <= r_state_nxt;
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && w_last_beat) w_state_nxt = W_RESP;
            W_RESP:  if (bready) w_state_nxt = W_IDLE;
            default: w_state_nxt = W_IDLE;
        endcase
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (r_hs && r_last_beat) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // rst_done keeps the ready outputs low until the first edge after reset release
    always_comb begin
        awready = rst_done && (w_state == W_IDLE);
        wready  = (w_state == W_DATA);
        bvalid  = (w_state == W_RESP);
        bid     = bvalid ? w_id : 4'd0;
        bresp   = (bvalid && w_err) ? SLVERR : OKAY;
        arready = rst_done && (r_state == R_IDLE);
        rvalid  = (r_state == R_DATA);
        rid     = rvalid ? r_id : 4'd0;
        rdata   = rvalid ? r_data_q : 32'd0;
        rresp   = rvalid ? r_resp_q : OKAY;
        rlast   = rvalid && r_last_beat;
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_id    <= awid;
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_cnt   <= '0;
            w_err   <= (awsize > 3'd2);
        end else if (w_hs) begin
            w_addr <= w_next;
            w_cnt  <= w_cnt + 4'd1;
            if (!w_beat_ok || (wlast != w_last_beat)) begin
                w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_mem_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) begin
                    mem[w_addr[2 +: AW]][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data is registered when a beat is loaded, so a same-cycle write lands after the read
    always_comb begin
        ld_addr = ar_hs ? araddr : r_next;
        ld_size = ar_hs ? arsize : r_size;
        ld_ok   = (ld_size <= 3'd2) && in_range(ld_addr);
        ld_data = ld_ok ? mem[ld_addr[2 +: AW]] : 32'd0;
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_size   <= '0;
            r_burst  <= '0;
            r_cnt    <= '0;
            r_data_q <= '0;
            r_resp_q <= OKAY;
        end else if (ar_hs) begin
            r_id     <= arid;
            r_addr   <= araddr;
            r_len    <= arlen;
            r_size   <= arsize;
            r_burst  <= arburst;
            r_cnt    <= '0;
            r_data_q <= ld_data;
            r_resp_q <= ld_ok ? OKAY : SLVERR;
        end else if (r_hs && !r_last_beat) begin
            r_addr   <= r_next;
            r_cnt    <= r_cnt + 4'd1;
            r_data_q <= ld_data;
            r_resp_q <= ld_ok ? OKAY : SLVERR;
        end
    end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
AXI3-style slave (responder) with an internal word-addressed memory, driven by the testbench master through the AXI interface. It accepts write bursts on AW/W and answers on B, and accepts read bursts on AR and returns data on R. It is used as the DUT-side responder in the AXI DV environment.

Parameters:
MEM_DEPTH, 64, number of 32-bit memory words; must be a power of 2; valid byte range is 0 to 4*MEM_DEPTH-1.

Ports:
aclk  in  1  clock; all logic on the rising edge
arst  in  1  synchronous, active-high reset
awid/awlen  in  4/4  write ID, beats minus 1
awaddr  in  32  write start byte address
awsize/awburst  in  3/2  bytes per beat (log2), burst type
awvalid/awready  in/out  1/1  AW handshake
wid  in  4  write-data ID
wdata/wstrb  in  32/4  write data, byte enables
wlast  in  1  last write beat
wvalid/wready  in/out  1/1  W handshake
bid/bresp  out  4/2  write response ID and code
bvalid/bready  out/in  1/1  B handshake
arid/arlen  in  4/4  read ID, beats minus 1
araddr  in  32  read start byte address
arsize/arburst  in  3/2  bytes per beat (log2), burst type
arvalid/arready  in/out  1/1  AR handshake
rid/rresp  out  4/2  read ID and response code
rdata  out  32  read data
rlast  out  1  last read beat
rvalid/rready  out/in  1/1  R handshake

Behaviour:
- Reset (arst=1 at an edge): every output is 0, the FSMs go to IDLE, and any burst in flight is aborted. Memory contents are not reset. awready and arready rise in the first cycle after arst is released.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On awvalid, capture id/addr/len/size/burst, clear the beat counter and error flag, then go to W_DATA.
  - W_DATA: wready=1. On each wvalid&wready, apply a byte write masked by wstrb to word addr[2+:log2(MEM_DEPTH)], then advance the address.
  - Burst end is set by count only: the beat with count==awlen goes to W_RESP. If wlast is asserted on any other beat, or is missing on that beat, the error flag is set.
  - W_RESP: bvalid=1, bid=captured id, bresp=SLVERR(2'b10) if the error flag is set, else OKAY(2'b00). Outputs hold until bready, then go to W_IDLE.
  - awready=0 outside W_IDLE, and wready=0 outside W_DATA.
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: arready=1. On arvalid, capture the request and go to R_DATA. rvalid rises the next cycle, giving 1-cycle latency.
  - R_DATA: rvalid=1, rid=captured id, rdata=mem[cur word]. rlast=1 when count==arlen.
  - On rready, advance; after the last beat go to R_IDLE. rdata/rresp/rlast stay stable while rvalid&!rready.
- Address generation:
  - FIXED(0): the address does not change.
  - INCR(1): addr+(1<<size).
  - WRAP(2): the wrap boundary is (len+1)<<size, aligned. A WRAP burst with len not in {1,3,7,15} is treated as INCR.
  - Reserved burst type (3) is treated as INCR.
- Errors:
  - size>2: the whole burst is SLVERR, with no memory writes and read data 0.
  - A beat address >= 4*MEM_DEPTH: the write is suppressed and the error flag set; on reads, rresp=SLVERR and rdata=0 for that beat only.
- Channels are independent. A read beat and a write to the same word in the same cycle: the read returns the pre-write data.

Optional Feature:
AXI_SLV_WID_CHECK_EN:
- Defined: a W beat whose wid differs from the captured awid suppresses its write and sets the error flag, giving bresp=SLVERR.
- Undefined: wid is ignored.

Decomposition:
- Package axi_slv_pkg holds: burst enum (FIXED/INCR/WRAP), response constants OKAY=2'b00 and SLVERR=2'b10, the write-state and read-state enums.
- Sub-module axi_slv_addr_gen: combinational next-address logic (addr, size, len, burst -> next addr). It is instantiated once for the write path and once for the read path.

Test Plan:
- Write awaddr=0x10, len=0, size=2, INCR, wdata=0xDEADBEEF, wstrb=4'hF -> bresp=0, bid=awid. Read back -> rdata=0xDEADBEEF, rlast=1, rresp=0.
- INCR len=3 at 0x20, data 1,2,3,4; read len=3 -> 4 beats 1..4, rlast on beat 4 only.
- WRAP len=3, size=2 at 0x38, data A,B,C,D -> words 0x38=A, 0x3C=B, 0x30=C, 0x34=D.
- Word at 0 is 0; write 0xFFFFFFFF with wstrb=4'b0101 -> read 0x00FF00FF.
- Hold bready=0 for 5 cycles -> bvalid/bresp held, awready=0. Toggle rready -> rdata stable until each handshake.
- awaddr=4*MEM_DEPTH -> bresp=SLVERR; read there -> rdata=0, rresp=SLVERR. Assert arst mid-burst -> all outputs 0 and both FSMs in IDLE.
